// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and a debug/loader port.
// One access at a time; the CPU normally wins, and a starved debug request is forced through.
module dmem_arbiter #(
   parameter int DATA_WIDTH      = 32,
   parameter int DATA_ADDR_WIDTH = 32,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cpuReq,
   input  logic                       cpuWrEnable,
   input  logic [DATA_ADDR_WIDTH-1:0] cpuAddr,
   input  logic [DATA_WIDTH-1:0]      cpuWrData,
   output logic [DATA_WIDTH-1:0]      cpuRdData,
   output logic                       cpuStall,
   input  logic                       dbgReq,
   input  logic                       dbgWrEnable,
   input  logic [DATA_ADDR_WIDTH-1:0] dbgAddr,
   input  logic [DATA_WIDTH-1:0]      dbgWrData,
   output logic [DATA_WIDTH-1:0]      dbgRdData,
   output logic                       dbgAck,
   output logic                       memReq,
   output logic                       memWrEnable,
   output logic [DATA_ADDR_WIDTH-1:0] memAddr,
   output logic [DATA_WIDTH-1:0]      memWrData,
   input  logic [DATA_WIDTH-1:0]      memRdData,
   input  logic                       memReady
);

   typedef enum logic [1:0] {IDLE, CPU_BUSY, DBG_BUSY, DBG_DONE} state_t;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t                     state_q, state_d;
   logic [3:0]                 starveCnt_q, starveCnt_d;
   logic                       memReq_q, memReq_d;
   logic                       memWrEnable_q, memWrEnable_d;
   logic [DATA_ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
   logic [DATA_WIDTH-1:0]      memWrData_q, memWrData_d;
   logic [DATA_WIDTH-1:0]      cpuRdData_q, cpuRdData_d;
   logic [DATA_WIDTH-1:0]      dbgRdData_q, dbgRdData_d;
   logic                       dbgAck_q, dbgAck_d;
   logic                       cpuDone;
   logic                       dbgStarved;

   assign cpuDone    = (state_q == CPU_BUSY) && memReady;
   assign dbgStarved = dbgReq && (starveCnt_q == STARVE_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         starveCnt_q   <= 4'd0;
         memReq_q      <= 1'b0;
         memWrEnable_q <= 1'b0;
         memAddr_q     <= '0;
         memWrData_q   <= '0;
         cpuRdData_q   <= '0;
         dbgRdData_q   <= '0;
         dbgAck_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         starveCnt_q   <= starveCnt_d;
         memReq_q      <= memReq_d;
         memWrEnable_q <= memWrEnable_d;
         memAddr_q     <= memAddr_d;
         memWrData_q   <= memWrData_d;
         cpuRdData_q   <= cpuRdData_d;
         dbgRdData_q   <= dbgRdData_d;
         dbgAck_q      <= dbgAck_d;
      end
   end

   // memWrEnable_q still holds the winner's direction during BUSY, so it tells loads from stores.
   always_comb begin
      state_d       = state_q;
      starveCnt_d   = starveCnt_q;
      memReq_d      = memReq_q;
      memWrEnable_d = memWrEnable_q;
      memAddr_d     = memAddr_q;
      memWrData_d   = memWrData_q;
      cpuRdData_d   = cpuRdData_q;
      dbgRdData_d   = dbgRdData_q;
      dbgAck_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (dbgStarved || (dbgReq && !cpuReq)) begin
               state_d       = DBG_BUSY;
               starveCnt_d   = 4'd0;
               memReq_d      = 1'b1;
               memWrEnable_d = dbgWrEnable;
               memAddr_d     = dbgAddr;
               memWrData_d   = dbgWrData;
            end else if (cpuReq) begin
               state_d       = CPU_BUSY;
               memReq_d      = 1'b1;
               memWrEnable_d = cpuWrEnable;
               memAddr_d     = cpuAddr;
               memWrData_d   = cpuWrData;
               if (dbgReq) starveCnt_d = starveCnt_q + 4'd1;
            end
         end
         CPU_BUSY: begin
            if (dbgReq && (starveCnt_q != STARVE_MAX)) starveCnt_d = starveCnt_q + 4'd1;
            if (memReady) begin
               state_d       = IDLE;
               memReq_d      = 1'b0;
               memWrEnable_d = 1'b0;
               if (!memWrEnable_q) cpuRdData_d = memRdData;
            end
         end
         DBG_BUSY: begin
            if (memReady) begin
               state_d       = DBG_DONE;
               memReq_d      = 1'b0;
               memWrEnable_d = 1'b0;
               dbgAck_d      = 1'b1;
               if (!memWrEnable_q) dbgRdData_d = memRdData;
            end
         end
         DBG_DONE: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Load data is forwarded in the completion cycle so the stalled pipeline can release immediately.
   assign cpuStall    = cpuReq && !cpuDone;
   assign cpuRdData   = (cpuDone && !memWrEnable_q) ? memRdData : cpuRdData_q;
   assign dbgRdData   = dbgRdData_q;
   assign dbgAck      = dbgAck_q;
   assign memReq      = memReq_q;
   assign memWrEnable = memWrEnable_q;
   assign memAddr     = memAddr_q;
   assign memWrData   = memWrData_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter; inputs change 1ns after the rising edge, outputs sampled 1ns later.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpuReq, cpuWrEnable, dbgReq, dbgWrEnable, memReady;
   logic [31:0] cpuAddr, cpuWrData, dbgAddr, dbgWrData, memRdData;
   logic [31:0] cpuRdData, dbgRdData, memAddr, memWrData;
   logic        cpuStall, dbgAck, memReq, memWrEnable;
   int          nChecks = 0;
   int          nFails  = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_WIDTH(32), .DATA_ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .cpuReq(cpuReq), .cpuWrEnable(cpuWrEnable), .cpuAddr(cpuAddr), .cpuWrData(cpuWrData),
      .cpuRdData(cpuRdData), .cpuStall(cpuStall),
      .dbgReq(dbgReq), .dbgWrEnable(dbgWrEnable), .dbgAddr(dbgAddr), .dbgWrData(dbgWrData),
      .dbgRdData(dbgRdData), .dbgAck(dbgAck),
      .memReq(memReq), .memWrEnable(memWrEnable), .memAddr(memAddr), .memWrData(memWrData),
      .memRdData(memRdData), .memReady(memReady)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; cpuReq = 0; cpuWrEnable = 0; cpuAddr = 0; cpuWrData = 0;
      dbgReq = 0; dbgWrEnable = 0; dbgAddr = 0; dbgWrData = 0; memReady = 0; memRdData = 0;
      tick; tick;
      #1;
      nChecks++; if (memReq !== 1'b0) begin nFails++; $display("[TB] FAIL rst_memReq: got %b expected 0", memReq); end
      nChecks++; if (memWrEnable !== 1'b0) begin nFails++; $display("[TB] FAIL rst_memWrEnable: got %b expected 0", memWrEnable); end
      nChecks++; if (memAddr !== 32'h0) begin nFails++; $display("[TB] FAIL rst_memAddr: got %h expected 0", memAddr); end
      nChecks++; if (memWrData !== 32'h0) begin nFails++; $display("[TB] FAIL rst_memWrData: got %h expected 0", memWrData); end
      nChecks++; if (cpuRdData !== 32'h0) begin nFails++; $display("[TB] FAIL rst_cpuRdData: got %h expected 0", cpuRdData); end
      nChecks++; if (dbgRdData !== 32'h0) begin nFails++; $display("[TB] FAIL rst_dbgRdData: got %h expected 0", dbgRdData); end
      nChecks++; if (dbgAck !== 1'b0) begin nFails++; $display("[TB] FAIL rst_dbgAck: got %b expected 0", dbgAck); end
      nChecks++; if (cpuStall !== 1'b0) begin nFails++; $display("[TB] FAIL rst_cpuStall: got %b expected 0", cpuStall); end
      tick;
      rst = 1'b0;
   endtask

   task automatic test_cpu_load;
      tick;
      memReady = 1; memRdData = 32'hDEADBEEF;
      cpuReq = 1; cpuWrEnable = 0; cpuAddr = 32'h10;
      #1;
      nChecks++; if (cpuStall !== 1'b1) begin nFails++; $display("[TB] FAIL ld_stall_idle: got %b expected 1", cpuStall); end
      nChecks++; if (memReq !== 1'b0) begin nFails++; $display("[TB] FAIL ld_memReq_idle: got %b expected 0", memReq); end
      tick;
      #1;
      nChecks++; if (memReq !== 1'b1) begin nFails++; $display("[TB] FAIL ld_memReq_busy: got %b expected 1", memReq); end
      nChecks++; if (memAddr !== 32'h10) begin nFails++; $display("[TB] FAIL ld_memAddr: got %h expected 10", memAddr); end
      nChecks++; if (memWrEnable !== 1'b0) begin nFails++; $display("[TB] FAIL ld_memWrEnable: got %b expected 0", memWrEnable); end
      nChecks++; if (cpuStall !== 1'b0) begin nFails++; $display("[TB] FAIL ld_stall_done: got %b expected 0", cpuStall); end
      nChecks++; if (cpuRdData !== 32'hDEADBEEF) begin nFails++; $display("[TB] FAIL ld_cpuRdData: got %h expected deadbeef", cpuRdData); end
      tick;
      cpuReq = 0; memRdData = 32'h0;
      #1;
      nChecks++; if (memReq !== 1'b0) begin nFails++; $display("[TB] FAIL ld_memReq_after: got %b expected 0", memReq); end
      nChecks++; if (cpuRdData !== 32'hDEADBEEF) begin nFails++; $display("[TB] FAIL ld_cpuRdData_hold: got %h expected deadbeef", cpuRdData); end
   endtask

   task automatic test_cpu_store;
      tick;
      memReady = 0; cpuReq = 1; cpuWrEnable = 1; cpuAddr = 32'h20; cpuWrData = 32'h55;
      #1;
      nChecks++; if (cpuStall !== 1'b1) begin nFails++; $display("[TB] FAIL st_stall_idle: got %b expected 1", cpuStall); end
      for (int i = 0; i < 4; i++) begin
         tick;
         memReady = (i == 3); memRdData = 32'hCAFEF00D;
         #1;
         nChecks++; if (memWrEnable !== 1'b1) begin nFails++; $display("[TB] FAIL st_memWrEnable[%0d]: got %b expected 1", i, memWrEnable); end
         nChecks++; if (memAddr !== 32'h20) begin nFails++; $display("[TB] FAIL st_memAddr[%0d]: got %h expected 20", i, memAddr); end
         nChecks++; if (memWrData !== 32'h55) begin nFails++; $display("[TB] FAIL st_memWrData[%0d]: got %h expected 55", i, memWrData); end
         nChecks++; if (cpuStall !== (i != 3)) begin nFails++; $display("[TB] FAIL st_stall[%0d]: got %b expected %b", i, cpuStall, (i != 3)); end
         nChecks++; if (cpuRdData !== 32'hDEADBEEF) begin nFails++; $display("[TB] FAIL st_cpuRdData[%0d]: got %h expected deadbeef", i, cpuRdData); end
      end
      tick;
      cpuReq = 0; memReady = 0;
      #1;
      nChecks++; if (memReq !== 1'b0) begin nFails++; $display("[TB] FAIL st_memReq_after: got %b expected 0", memReq); end
      nChecks++; if (memWrEnable !== 1'b0) begin nFails++; $display("[TB] FAIL st_memWrEnable_after: got %b expected 0", memWrEnable); end
   endtask

   task automatic test_dbg_load;
      tick;
      memReady = 1; memRdData = 32'h1234;
      dbgReq = 1; dbgWrEnable = 0; dbgAddr = 32'h08;
      #1;
      nChecks++; if (memReq !== 1'b0) begin nFails++; $display("[TB] FAIL dl_memReq_idle: got %b expected 0", memReq); end
      tick;
      #1;
      nChecks++; if (memReq !== 1'b1) begin nFails++; $display("[TB] FAIL dl_memReq_busy: got %b expected 1", memReq); end
      nChecks++; if (memAddr !== 32'h08) begin nFails++; $display("[TB] FAIL dl_memAddr: got %h expected 08", memAddr); end
      nChecks++; if (dbgAck !== 1'b0) begin nFails++; $display("[TB] FAIL dl_ack_busy: got %b expected 0", dbgAck); end
      tick;
      memRdData = 32'h0;
      #1;
      nChecks++; if (dbgAck !== 1'b1) begin nFails++; $display("[TB] FAIL dl_ack_done: got %b expected 1", dbgAck); end
      nChecks++; if (dbgRdData !== 32'h1234) begin nFails++; $display("[TB] FAIL dl_dbgRdData: got %h expected 1234", dbgRdData); end
      nChecks++; if (memReq !== 1'b0) begin nFails++; $display("[TB] FAIL dl_memReq_done: got %b expected 0", memReq); end
      tick;
      dbgReq = 0;
      #1;
      nChecks++; if (memReq !== 1'b0) begin nFails++; $display("[TB] FAIL dl_no_grant_in_done: got %b expected 0", memReq); end
      nChecks++; if (dbgAck !== 1'b0) begin nFails++; $display("[TB] FAIL dl_ack_single: got %b expected 0", dbgAck); end
      nChecks++; if (dbgRdData !== 32'h1234) begin nFails++; $display("[TB] FAIL dl_dbgRdData_hold: got %h expected 1234", dbgRdData); end
      memReady = 0;
   endtask

   task automatic test_cpu_during_dbg;
      tick;
      memReady = 0; dbgReq = 1; dbgWrEnable = 0; dbgAddr = 32'h0C;
      #1;
      nChecks++; if (cpuStall !== 1'b0) begin nFails++; $display("[TB] FAIL cd_stall_noreq: got %b expected 0", cpuStall); end
      tick;
      cpuReq = 1; cpuWrEnable = 0; cpuAddr = 32'h30;
      #1;
      nChecks++; if (cpuStall !== 1'b1) begin nFails++; $display("[TB] FAIL cd_stall_dbgbusy: got %b expected 1", cpuStall); end
      tick;
      memReady = 1; memRdData = 32'h77;
      #1;
      nChecks++; if (cpuStall !== 1'b1) begin nFails++; $display("[TB] FAIL cd_stall_dbgdone_cycle: got %b expected 1", cpuStall); end
      nChecks++; if (memAddr !== 32'h0C) begin nFails++; $display("[TB] FAIL cd_memAddr_dbg: got %h expected 0c", memAddr); end
      tick;
      dbgReq = 0;
      #1;
      nChecks++; if (dbgAck !== 1'b1) begin nFails++; $display("[TB] FAIL cd_ack: got %b expected 1", dbgAck); end
      nChecks++; if (dbgRdData !== 32'h77) begin nFails++; $display("[TB] FAIL cd_dbgRdData: got %h expected 77", dbgRdData); end
      nChecks++; if (cpuStall !== 1'b1) begin nFails++; $display("[TB] FAIL cd_stall_ack: got %b expected 1", cpuStall); end
      tick;
      #1;
      nChecks++; if (memReq !== 1'b0) begin nFails++; $display("[TB] FAIL cd_idle_gap: got %b expected 0", memReq); end
      nChecks++; if (cpuStall !== 1'b1) begin nFails++; $display("[TB] FAIL cd_stall_idle: got %b expected 1", cpuStall); end
      tick;
      memRdData = 32'h99;
      #1;
      nChecks++; if (memAddr !== 32'h30) begin nFails++; $display("[TB] FAIL cd_memAddr_cpu: got %h expected 30", memAddr); end
      nChecks++; if (cpuStall !== 1'b0) begin nFails++; $display("[TB] FAIL cd_stall_cpudone: got %b expected 0", cpuStall); end
      nChecks++; if (cpuRdData !== 32'h99) begin nFails++; $display("[TB] FAIL cd_cpuRdData: got %h expected 99", cpuRdData); end
      tick;
      cpuReq = 0;
   endtask

   task automatic test_starvation;
      logic [31:0] expAddr [1:8];
      logic        expReq  [0:8];
      expAddr = '{32'h40, 32'h0, 32'h40, 32'h0, 32'h50, 32'h0, 32'h0, 32'h40};
      expReq  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      memReady = 1; memRdData = 32'h11;
      cpuReq = 1; cpuWrEnable = 0; cpuAddr = 32'h40;
      dbgReq = 1; dbgWrEnable = 1; dbgAddr = 32'h50; dbgWrData = 32'hAB;
      #1;
      nChecks++; if (memReq !== expReq[0]) begin nFails++; $display("[TB] FAIL sv_memReq[0]: got %b expected %b", memReq, expReq[0]); end
      for (int c = 1; c <= 8; c++) begin
         tick;
         if (c == 6) dbgReq = 0;
         if (c == 7) dbgReq = 1;
         #1;
         nChecks++; if (memReq !== expReq[c]) begin nFails++; $display("[TB] FAIL sv_memReq[%0d]: got %b expected %b", c, memReq, expReq[c]); end
         if (expReq[c]) begin
            nChecks++; if (memAddr !== expAddr[c]) begin nFails++; $display("[TB] FAIL sv_memAddr[%0d]: got %h expected %h", c, memAddr, expAddr[c]); end
         end
         nChecks++; if (dbgAck !== (c == 6)) begin nFails++; $display("[TB] FAIL sv_dbgAck[%0d]: got %b expected %b", c, dbgAck, (c == 6)); end
      end
      nChecks++; if (dbgRdData !== 32'h77) begin nFails++; $display("[TB] FAIL sv_dbgRdData_store: got %h expected 77", dbgRdData); end
      tick;
      cpuReq = 0; dbgReq = 0; memReady = 0;
   endtask

   task automatic test_reset_mid_access;
      tick;
      memReady = 0; cpuReq = 1; cpuWrEnable = 0; cpuAddr = 32'h60;
      tick;
      #1;
      nChecks++; if (memReq !== 1'b1) begin nFails++; $display("[TB] FAIL rm_memReq_busy: got %b expected 1", memReq); end
      #2;
      rst = 1'b1; memReady = 1; memRdData = 32'h5A5A;
      #1;
      nChecks++; if (memReq !== 1'b0) begin nFails++; $display("[TB] FAIL rm_memReq_async: got %b expected 0", memReq); end
      nChecks++; if (cpuStall !== 1'b1) begin nFails++; $display("[TB] FAIL rm_stall_async: got %b expected 1", cpuStall); end
      nChecks++; if (cpuRdData !== 32'h0) begin nFails++; $display("[TB] FAIL rm_cpuRdData_async: got %h expected 0", cpuRdData); end
      tick;
      rst = 1'b0; memReady = 0;
      #1;
      nChecks++; if (memReq !== 1'b0) begin nFails++; $display("[TB] FAIL rm_memReq_idle: got %b expected 0", memReq); end
      tick;
      memReady = 1; memRdData = 32'h4242;
      #1;
      nChecks++; if (memReq !== 1'b1) begin nFails++; $display("[TB] FAIL rm_regrant: got %b expected 1", memReq); end
      nChecks++; if (memAddr !== 32'h60) begin nFails++; $display("[TB] FAIL rm_memAddr: got %h expected 60", memAddr); end
      nChecks++; if (cpuRdData !== 32'h4242) begin nFails++; $display("[TB] FAIL rm_cpuRdData: got %h expected 4242", cpuRdData); end
      tick;
      cpuReq = 0; memReady = 0;
   endtask

   initial begin
      test_reset;
      test_cpu_load;
      test_cpu_store;
      test_dbg_load;
      test_cpu_during_dbg;
      test_starvation;
      test_reset_mid_access;
      tick;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
